// File: rtl/iic_slave_pkg.sv
// Shared definitions for the I2C register-access slave.
package iic_slave_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    ACK_DEV,
    REG_H,
    ACK_RH,
    REG_L,
    ACK_RL,
    WR,
    ACK_WR,
    RD,
    RD_ACK,
    WAIT_STOP
  } iic_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Post-byte register address step; 8-bit mode keeps the high byte at zero.
  function automatic logic [15:0] next_reg_addr(input logic [15:0] addr,
                                                input logic        wide);
    if (wide) begin
      return addr + 16'd1;
    end
    return {8'h00, addr[7:0] + 8'd1};
  endfunction

endpackage

// File: rtl/iic_slave_bus_sync.sv
// SCL/SDA synchronizers plus START, STOP and SCL edge detection.
module iic_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0] metastability flop, [1] synchronized value, [2] one-cycle delayed copy
  logic [2:0] scl_pipe_q, scl_pipe_d;
  logic [2:0] sda_pipe_q, sda_pipe_d;

  // Shift the raw bus lines into their pipelines.
  always_comb begin
    scl_pipe_d = {scl_pipe_q[1:0], scl_in};
    sda_pipe_d = {sda_pipe_q[1:0], sda_in};
  end

  // Pipelines idle high so a quiet bus never looks like an edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_pipe_q <= '1;
      sda_pipe_q <= '1;
    end else begin
      scl_pipe_q <= scl_pipe_d;
      sda_pipe_q <= sda_pipe_d;
    end
  end

  assign sda_s     = sda_pipe_q[1];
  assign scl_rise  =  scl_pipe_q[1] & ~scl_pipe_q[2];
  assign scl_fall  = ~scl_pipe_q[1] &  scl_pipe_q[2];
  assign start_det =  scl_pipe_q[1] &  scl_pipe_q[2] & ~sda_pipe_q[1] &  sda_pipe_q[2];
  assign stop_det  =  scl_pipe_q[1] &  scl_pipe_q[2] &  sda_pipe_q[1] & ~sda_pipe_q[2];

endmodule

// File: rtl/iic_slave.sv
// I2C slave bridging bus transfers onto a byte-wide register bank.
module iic_slave
  import iic_slave_pkg::*;
#(
  parameter logic [7:0]  SLAVE_ADDR = 8'h78,
  parameter int unsigned REG_EX     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);

  localparam logic REG_WIDE = (REG_EX != 0);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  iic_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  iic_state_e  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rd_shift_q, rd_shift_d;
  logic        rw_q, rw_d;
  logic        ack_seen_q, ack_seen_d;
  logic        rd_load_q, rd_load_d;
  logic        sda_oe_q, sda_oe_d;
  logic        reg_wr_en_q, reg_wr_en_d;
  logic        reg_rd_en_q, reg_rd_en_d;
  logic [15:0] reg_addr_q, reg_addr_d;
  logic [7:0]  reg_wdata_q, reg_wdata_d;
  logic        busy_q, busy_d;
  logic [7:0]  byte_in;

  // Next-state and output decode, driven by bus events.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rd_shift_d  = rd_shift_q;
    rw_d        = rw_q;
    ack_seen_d  = ack_seen_q;
    rd_load_d   = reg_rd_en_q;
    sda_oe_d    = sda_oe_q;
    reg_wr_en_d = 1'b0;
    reg_rd_en_d = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    byte_in     = {shift_q[6:0], sda_s};

    // Address advances the cycle after the write strobe, so the strobe
    // itself always carries the address the byte was aimed at.
    if (reg_wr_en_q) begin
      reg_addr_d = next_reg_addr(reg_addr_q, REG_WIDE);
    end

    // Bank data is valid one cycle after the fetch strobe; put its MSB on the bus.
    if (rd_load_q && state_q == RD) begin
      rd_shift_d = reg_rdata;
      sda_oe_d   = ~reg_rdata[7];
    end

    if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else if (start_det) begin
      state_d    = DEV;
      bit_cnt_d  = '0;
      ack_seen_d = 1'b0;
    end else if (scl_rise) begin
      unique case (state_q)
        DEV, REG_H, REG_L, WR: begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            unique case (state_q)
              DEV: begin
                if (byte_in[7:1] == SLAVE_ADDR[7:1]) begin
                  state_d = ACK_DEV;
                  rw_d    = byte_in[0];
                end else begin
                  state_d = WAIT_STOP;
                end
              end
              REG_H: begin
                reg_addr_d[15:8] = byte_in;
                state_d          = ACK_RH;
              end
              REG_L: begin
                reg_addr_d = REG_WIDE ? {reg_addr_q[15:8], byte_in} : {8'h00, byte_in};
                state_d    = ACK_RL;
              end
              default: begin
                reg_wdata_d = byte_in;
                reg_wr_en_d = 1'b1;
                state_d     = ACK_WR;
              end
            endcase
          end
        end
        RD: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d    = RD_ACK;
            ack_seen_d = 1'b0;
          end
        end
        RD_ACK: begin
          if (sda_s == ACK) begin
            ack_seen_d = 1'b1;
            reg_addr_d = next_reg_addr(reg_addr_q, REG_WIDE);
          end else begin
            state_d = WAIT_STOP;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      unique case (state_q)
        // First fall in an ACK state starts driving the ACK, the second ends it.
        ACK_DEV, ACK_RH, ACK_RL, ACK_WR: begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            unique case (state_q)
              ACK_DEV: begin
                if (rw_q) begin
                  state_d     = RD;
                  reg_rd_en_d = 1'b1;
                  bit_cnt_d   = '0;
                end else begin
                  state_d = REG_WIDE ? REG_H : REG_L;
                end
              end
              ACK_RH:  state_d = REG_L;
              default: state_d = WR;
            endcase
          end
        end
        RD: begin
          rd_shift_d = {rd_shift_q[6:0], 1'b0};
          sda_oe_d   = ~rd_shift_q[6];
        end
        RD_ACK: begin
          if (ack_seen_q) begin
            state_d     = RD;
            reg_rd_en_d = 1'b1;
            bit_cnt_d   = '0;
          end else begin
            sda_oe_d = 1'b0;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset releases SDA asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rd_shift_q  <= '0;
      rw_q        <= 1'b0;
      ack_seen_q  <= 1'b0;
      rd_load_q   <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_wr_en_q <= 1'b0;
      reg_rd_en_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rd_shift_q  <= rd_shift_d;
      rw_q        <= rw_d;
      ack_seen_q  <= ack_seen_d;
      rd_load_q   <= rd_load_d;
      sda_oe_q    <= sda_oe_d;
      reg_wr_en_q <= reg_wr_en_d;
      reg_rd_en_q <= reg_rd_en_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_wr_en = reg_wr_en_q;
  assign reg_rd_en = reg_rd_en_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_iic_slave.sv
// Self-checking bench for iic_slave: bus master tasks, register bank and a
// transaction-level model of expected register accesses.
module tb_iic_slave;

  localparam int Q = 300;   // quarter SCL period in time units (clk period 20)

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl_m, sda_m;
  logic        sda_bus;
  logic        sda_oe, reg_wr_en, reg_rd_en, busy;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata, reg_rdata;

  assign sda_bus = sda_m & ~sda_oe;

  always #10 clk = ~clk;

  iic_slave #(.SLAVE_ADDR(8'h78), .REG_EX(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_m),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  int          checks   = 0;
  int          failures = 0;
  wr_t         wr_obs[$], wr_exp[$];
  logic [15:0] rd_obs[$];
  int          overlap  = 0;
  logic        oe_seen  = 1'b0;
  logic [7:0]  mem [0:65535];
  logic [15:0] m_addr;

  // Register bank: data appears the cycle after the fetch strobe.
  always @(posedge clk) begin
    if (reg_rd_en) reg_rdata <= mem[reg_addr];
  end

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reg_wr_en) wr_obs.push_back('{reg_addr, reg_wdata});
    if (reg_rd_en) rd_obs.push_back(reg_addr);
    if (reg_wr_en && reg_rd_en) overlap++;
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic send_bits(input logic [7:0] b, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      sda_m = b[7-i]; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    send_bits(b, 8);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; a = sda_bus; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    sda_m = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      #Q; scl_m = 1'b1; #Q; d[7-i] = sda_bus; #Q; scl_m = 1'b0;
    end
    sda_m = mack; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q; sda_m = 1'b1;
  endtask

  // Model: a matching write sets the pointer from the two address bytes,
  // each data byte lands at the pointer, and the pointer wraps at 16 bits.
  task automatic model_write(input logic [7:0] dev, input logic [15:0] addr,
                             input int unsigned n, input logic [23:0] data);
    if (dev[7:1] == 7'h3C) begin
      m_addr = addr;
      for (int unsigned i = 0; i < n; i++) begin
        wr_exp.push_back('{m_addr, data[8*i +: 8]});
        m_addr = m_addr + 16'd1;
      end
    end
  endtask

  // Full write transfer; the ACK expected on the address byte comes from the caller.
  task automatic do_write(input string nm, input logic [7:0] dev, input logic [15:0] addr,
                          input int unsigned n, input logic [23:0] data, input logic exp_ack);
    logic a;
    i2c_start();
    write_byte(dev, a);
    check({nm, "_dev_ack"}, 32'(a), 32'(exp_ack));
    if (a == 1'b0) begin
      write_byte(addr[15:8], a);
      check({nm, "_rh_ack"}, 32'(a), 0);
      write_byte(addr[7:0], a);
      check({nm, "_rl_ack"}, 32'(a), 0);
      for (int unsigned i = 0; i < n; i++) begin
        write_byte(data[8*i +: 8], a);
        check($sformatf("%s_wr%0d_ack", nm, i), 32'(a), 0);
      end
    end
    i2c_stop();
    model_write(dev, addr, n, data);
  endtask

  task automatic compare_writes(input string nm);
    #Q;
    check({nm, "_wr_count"}, 32'(wr_obs.size()), 32'(wr_exp.size()));
    for (int i = 0; i < wr_obs.size() && i < wr_exp.size(); i++) begin
      check($sformatf("%s_wr%0d_addr", nm, i), 32'(wr_obs[i].addr), 32'(wr_exp[i].addr));
      check($sformatf("%s_wr%0d_data", nm, i), 32'(wr_obs[i].data), 32'(wr_exp[i].data));
    end
    wr_obs.delete();
    wr_exp.delete();
  endtask

  // Set pointer, repeated START, read n bytes (ACK all but the last).
  task automatic do_read(input string nm, input logic [15:0] addr, input int unsigned n);
    logic       a;
    logic [7:0] d;
    i2c_start();
    write_byte(8'h78, a);
    check({nm, "_wdev_ack"}, 32'(a), 0);
    write_byte(addr[15:8], a);
    write_byte(addr[7:0], a);
    i2c_start();
    write_byte(8'h79, a);
    check({nm, "_rdev_ack"}, 32'(a), 0);
    for (int unsigned i = 0; i < n; i++) begin
      read_byte((i == n - 1) ? 1'b1 : 1'b0, d);
      check($sformatf("%s_rd%0d_data", nm, i), 32'(d), 32'(mem[16'(addr + 16'(i))]));
    end
    check({nm, "_released"}, 32'(sda_oe), 0);
    i2c_stop();
    #Q;
    check({nm, "_rd_count"}, 32'(rd_obs.size()), 32'(n));
    for (int i = 0; i < rd_obs.size() && i < int'(n); i++) begin
      check($sformatf("%s_rd%0d_addr", nm, i), 32'(rd_obs[i]), 32'(16'(addr + 16'(i))));
    end
    rd_obs.delete();
    check({nm, "_no_writes"}, 32'(wr_obs.size()), 0);
  endtask

  typedef struct {
    logic [7:0]  dev;
    logic [15:0] addr;
    int unsigned n;
    logic [23:0] data;      // byte i at bits [8i+7:8i]
    logic        exp_ack;
    int unsigned exp_nwr;
  } wvec_t;

  wvec_t vec [4];

  initial begin
    logic        a;
    logic [7:0]  dev;
    logic [15:0] addr;
    logic [23:0] data;
    int unsigned n;

    vec[0] = '{8'h78, 16'h3008, 1, 24'h000082, 1'b0, 1};
    vec[1] = '{8'h78, 16'h3017, 3, 24'h332211, 1'b0, 3};
    vec[2] = '{8'h78, 16'hFFFF, 2, 24'h005AA5, 1'b0, 2};
    vec[3] = '{8'h7A, 16'h1234, 1, 24'h000077, 1'b1, 0};

    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
    mem[16'h300A] = 8'h56;
    mem[16'h300B] = 8'h40;

    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; reg_rdata = 8'h00;
    #(3*Q);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_strobes", 32'({reg_wr_en, reg_rd_en}), 0);
    check("rst_addr", 32'(reg_addr), 0);
    check("rst_wdata", 32'(reg_wdata), 0);
    rst_n = 1'b1;
    #(2*Q);

    // Table-driven write transfers.
    for (int i = 0; i < 4; i++) begin
      do_write($sformatf("vec%0d", i), vec[i].dev, vec[i].addr, vec[i].n, vec[i].data, vec[i].exp_ack);
      check($sformatf("vec%0d_nwr_tbl", i), 32'(wr_obs.size()), 32'(vec[i].exp_nwr));
      compare_writes($sformatf("vec%0d", i));
    end

    // Randomized writes against the model.
    for (int i = 0; i < 6; i++) begin
      dev  = (($urandom % 3) == 0) ? (8'($urandom) & 8'hFE) : 8'h78;
      addr = 16'($urandom);
      n    = $urandom_range(1, 3);
      data = 24'($urandom);
      do_write($sformatf("rnd%0d", i), dev, addr, n, data, (dev[7:1] == 7'h3C) ? 1'b0 : 1'b1);
      compare_writes($sformatf("rnd%0d", i));
    end

    // Random read after repeated START, then a randomized one.
    do_read("read300a", 16'h300A, 2);
    do_read("readrnd", 16'($urandom), $urandom_range(1, 3));

    // Address mismatch: never drive SDA, no strobes, busy until STOP.
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'h42, a);
    check("mis_dev_nack", 32'(a), 1);
    write_byte(8'h55, a);
    check("mis_busy_mid", 32'(busy), 1);
    i2c_stop();
    #Q;
    check("mis_busy_after", 32'(busy), 0);
    check("mis_oe_seen", 32'(oe_seen), 0);
    check("mis_strobes", 32'(wr_obs.size() + rd_obs.size()), 0);

    // Wrap at 0xFFFF, then a STOP after four bits of a third byte.
    i2c_start();
    write_byte(8'h78, a);
    write_byte(8'hFF, a);
    write_byte(8'hFF, a);
    write_byte(8'h11, a);
    write_byte(8'h22, a);
    check("wrap_d2_ack", 32'(a), 0);
    send_bits(8'h33, 4);
    scl_m = 1'b0;
    i2c_stop();
    model_write(8'h78, 16'hFFFF, 2, 24'h002211);
    compare_writes("wrap_abort");

    // Reset asserted while the slave drives the address ACK.
    i2c_start();
    send_bits(8'h78, 8);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
    check("rstmid_acking", 32'(sda_oe), 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_release", 32'(sda_oe), 0);
    check("rstmid_busy", 32'(busy), 0);
    #Q; rst_n = 1'b1; scl_m = 1'b0; #Q;
    write_byte(8'h78, a);
    check("rstmid_ignored", 32'(a), 1);
    i2c_stop();
    #Q;
    check("rstmid_no_strobe", 32'(wr_obs.size() + rd_obs.size()), 0);
    do_write("after_rst", 8'h78, 16'h0042, 1, 24'h0000C3, 1'b0);
    compare_writes("after_rst");

    check("no_wr_rd_overlap", 32'(overlap), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
